// File: rtl/reaction_timer.sv
// reaction_timer: reaction-game control (random wait, stimulus, ms score).
// Optional false-start detection is enabled by defining REACTION_FALSE_START_EN.
module reaction_timer #(
  parameter int TICK_DIV    = 50000,
  parameter int MIN_WAIT_MS = 1000
) (
  input  logic        Clock,
  input  logic        CLRN,
  input  logic        Start,
  input  logic        React,
  output logic [12:0] Score,
  output logic        Load,
  output logic        Display,
  output logic        Stimulus,
  output logic        TooSoon
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [13:0] MS_MAX = 14'd8191;
  localparam logic [13:0] MIN_W = 14'(MIN_WAIT_MS);
  localparam logic [15:0] LFSR_RST = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TIMING,
`ifdef REACTION_FALSE_START_EN
    S_FALSE,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          prev_start_q;
  logic          prev_react_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [13:0]   ms_q, ms_d;
  logic [13:0]   wait_q, wait_d;
  logic [12:0]   score_q, score_d;
  logic          load_q, load_d;
  logic          disp_q, disp_d;
  logic          stim_q, stim_d;
`ifdef REACTION_FALSE_START_EN
  logic          too_soon_q, too_soon_d;
`endif

  logic start_edge;
  logic react_edge;
  logic tick;
  logic lfsr_fb;

  assign start_edge = Start & ~prev_start_q;
  assign react_edge = React & ~prev_react_q;
  assign tick       = (pre_q == PRE_MAX);

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    ms_d    = ms_q;
    wait_d  = wait_q;
    score_d = score_q;
    load_d  = 1'b0;
    disp_d  = disp_q;
    stim_d  = stim_q;
`ifdef REACTION_FALSE_START_EN
    too_soon_d = too_soon_q;
`endif
    case (state_q)
      S_WAIT: begin
`ifdef REACTION_FALSE_START_EN
        if (react_edge) begin
          state_d    = S_FALSE;
          score_d    = 13'h1FFF;
          load_d     = 1'b1;
          disp_d     = 1'b1;
          too_soon_d = 1'b1;
        end else
`endif
        if (tick) begin
          if (ms_q == wait_q - 14'd1) begin
            state_d = S_TIMING;
            stim_d  = 1'b1;
            ms_d    = '0;
            pre_d   = '0;
          end else begin
            ms_d = ms_q + 14'd1;
          end
        end
      end
      S_TIMING: begin
        // React beats a coincident tick, so the score is pre-increment
        if (react_edge) begin
          state_d = S_DONE;
          score_d = ms_q[12:0];
          load_d  = 1'b1;
          disp_d  = 1'b1;
          stim_d  = 1'b0;
        end else if (ms_q == MS_MAX) begin
          state_d = S_DONE;
          score_d = 13'h1FFF;
          load_d  = 1'b1;
          disp_d  = 1'b1;
          stim_d  = 1'b0;
        end else if (tick) begin
          ms_d = ms_q + 14'd1;
        end
      end
      default: begin
        if (start_edge) begin
          state_d = S_WAIT;
          wait_d  = MIN_W + {3'b000, lfsr_q[10:0]};
          ms_d    = '0;
          pre_d   = '0;
          disp_d  = 1'b0;
          stim_d  = 1'b0;
`ifdef REACTION_FALSE_START_EN
          too_soon_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!CLRN) begin
      state_q      <= S_IDLE;
      prev_start_q <= 1'b0;
      prev_react_q <= 1'b0;
      pre_q        <= '0;
      lfsr_q       <= LFSR_RST;
      ms_q         <= '0;
      wait_q       <= '0;
      score_q      <= '0;
      load_q       <= 1'b0;
      disp_q       <= 1'b0;
      stim_q       <= 1'b0;
`ifdef REACTION_FALSE_START_EN
      too_soon_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_start_q <= Start;
      prev_react_q <= React;
      pre_q        <= pre_d;
      lfsr_q       <= lfsr_d;
      ms_q         <= ms_d;
      wait_q       <= wait_d;
      score_q      <= score_d;
      load_q       <= load_d;
      disp_q       <= disp_d;
      stim_q       <= stim_d;
`ifdef REACTION_FALSE_START_EN
      too_soon_q   <= too_soon_d;
`endif
    end
  end

  assign Score    = score_q;
  assign Load     = load_q;
  assign Display  = disp_q;
  assign Stimulus = stim_q;
`ifdef REACTION_FALSE_START_EN
  assign TooSoon  = too_soon_q;
`else
  assign TooSoon  = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed checks of reaction_timer with
// TICK_DIV=4, MIN_WAIT_MS=2.
module tb_reaction_timer;

  logic        clk;
  logic        clrn;
  logic        start;
  logic        react;
  logic [12:0] score;
  logic        load;
  logic        disp;
  logic        stim;
  logic        too_soon;

  logic [15:0] m_lfsr;
  int          n_vec;
  int          n_err;
  int          w;

  reaction_timer #(
    .TICK_DIV   (4),
    .MIN_WAIT_MS(2)
  ) dut (
    .Clock   (clk),
    .CLRN    (clrn),
    .Start   (start),
    .React   (react),
    .Score   (score),
    .Load    (load),
    .Display (disp),
    .Stimulus(stim),
    .TooSoon (too_soon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // taps 16,14,13,11 of the right-shifting register sit at bits 0,2,3,5
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  always @(posedge clk) begin
    if (!clrn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves the bench just after the Start-accept edge
  task automatic accept_start(output int wm);
    wm = 2 + int'(m_lfsr[10:0]);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // 'done' = edges already passed since the Start-accept edge
  task automatic expect_stim(input int wm, input int done);
    step(4 * wm - 1 - done);
    chk("stim_pre", 32'(stim), 32'd0);
    step(1);
    chk("stim_rise", 32'(stim), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clrn  = 1'b0;
    start = 1'b0;
    react = 1'b0;
    step(3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_toosoon", 32'(too_soon), 32'd0);
    clrn = 1'b1;
    step(1);

    react = 1'b1;
    step(1);
    chk("idle_react_load", 32'(load), 32'd0);
    chk("idle_react_stim", 32'(stim), 32'd0);
    react = 1'b0;
    step(1);

    accept_start(w);
    chk("wait_disp", 32'(disp), 32'd0);
    step(2);
    react = 1'b1;
    step(1);
`ifdef REACTION_FALSE_START_EN
    chk("fs_load", 32'(load), 32'd1);
    chk("fs_score", 32'(score), 32'd8191);
    chk("fs_toosoon", 32'(too_soon), 32'd1);
    chk("fs_disp", 32'(disp), 32'd1);
    chk("fs_stim", 32'(stim), 32'd0);
    react = 1'b0;
    step(1);
    chk("fs_load_drop", 32'(load), 32'd0);
    accept_start(w);
    chk("fs_clear", 32'(too_soon), 32'd0);
    chk("fs_disp_clr", 32'(disp), 32'd0);
    expect_stim(w, 0);
`else
    chk("nofs_load", 32'(load), 32'd0);
    chk("nofs_toosoon", 32'(too_soon), 32'd0);
    react = 1'b0;
    expect_stim(w, 3);
`endif
    step(40);
    react = 1'b1;
    step(1);
    chk("r10_score", 32'(score), 32'd10);
    chk("r10_load", 32'(load), 32'd1);
    chk("r10_disp", 32'(disp), 32'd1);
    chk("r10_stim", 32'(stim), 32'd0);
    react = 1'b0;
    step(1);
    chk("r10_load_drop", 32'(load), 32'd0);
    chk("r10_disp_hold", 32'(disp), 32'd1);

    accept_start(w);
    chk("done_start_disp", 32'(disp), 32'd0);
    chk("done_start_score", 32'(score), 32'd10);
    expect_stim(w, 0);
    step(23);
    react = 1'b1;
    step(1);
    chk("tie_score", 32'(score), 32'd5);
    chk("tie_load", 32'(load), 32'd1);
    react = 1'b0;
    step(1);
    chk("tie_load_drop", 32'(load), 32'd0);

    accept_start(w);
    expect_stim(w, 0);
    step(5);
    clrn = 1'b0;
    step(1);
    chk("abort_stim", 32'(stim), 32'd0);
    chk("abort_load", 32'(load), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    chk("abort_disp", 32'(disp), 32'd0);
    clrn = 1'b1;
    step(2);
    chk("abort_no_load", 32'(load), 32'd0);

    react = 1'b1;
    accept_start(w);
    expect_stim(w, 0);
    step(32764);
    chk("to_pre_load", 32'(load), 32'd0);
    chk("to_pre_stim", 32'(stim), 32'd1);
    step(1);
    chk("to_score", 32'(score), 32'd8191);
    chk("to_load", 32'(load), 32'd1);
    chk("to_disp", 32'(disp), 32'd1);
    chk("to_stim", 32'(stim), 32'd0);
    step(1);
    chk("to_load_drop", 32'(load), 32'd0);
    react = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Game-control stage for the reaction-time game, feeding the score display stage. On a Start press it waits a pseudo-random delay, then raises the stimulus LED and counts elapsed milliseconds until the React press. It then delivers a 13-bit millisecond score, a one-cycle load strobe and a display-enable level, which the display stage latches and shows on four seven-segment digits.

## Interface
- TICK_DIV, 50000: Clock cycles per millisecond tick. 50000 corresponds to a 50 MHz clock. Must be ≥ 2.
- MIN_WAIT_MS, 1000: Minimum random-wait length in ms.
- Clock  in  1  Sole clock. All logic updates on the rising edge.
- CLRN  in  1  Reset. Synchronous and active-low.
- Start  in  1  Start button. Already synchronised and debounced. Acts on its rising edge.
- React  in  1  Reaction button. Already synchronised and debounced. Acts on its rising edge.
- Score  out  13  Last result in ms, 0–8191. Registered.
- Load  out  1  One-cycle strobe, high in the cycle in which Score holds a new result.
- Display  out  1  Display enable. High while a result is valid.
- Stimulus  out  1  LED drive. High while the player must react.
- TooSoon  out  1  Set by a false start. Cleared by the next accepted Start.

## Operation
- Edge detect:
  - Prev registers Start and React.
  - edge = In & ~Prev, evaluated combinationally.
  - Prev clears to 0 on reset.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is asserted when the count is TICK_DIV-1.
  - The count is zeroed on every entry into WAIT and TIMING.
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Reset value 16'hACE1. Advances every cycle in all states.
- States: IDLE, WAIT, TIMING, DONE, FALSE.
- IDLE / DONE / FALSE, on a Start edge:
  - Go to WAIT.
  - wait_ms = MIN_WAIT_MS + lfsr[10:0], 14-bit, zero-extended add.
  - ms_cnt = 0. Display = 0. Stimulus = 0. TooSoon = 0.
  - Score keeps its old value.
- WAIT:
  - Each tick increments ms_cnt.
  - On a tick with ms_cnt == wait_ms-1: go to TIMING, Stimulus = 1, ms_cnt = 0.
- TIMING:
  - Each tick increments ms_cnt, saturating at 8191.
  - React edge: go to DONE; Score = ms_cnt (completed ms), Load = 1, Display = 1, Stimulus = 0.
  - Timeout: ms_cnt == 8191 with no React edge. Go to DONE with Score = 8191, Load = 1, Display = 1, Stimulus = 0.
- Ignored inputs:
  - Start edges in WAIT and TIMING.
  - React edges in IDLE and DONE.
- Load is high for exactly one cycle per result and never high in two consecutive cycles.
- Simultaneous events:
  - React edge and tick in the same TIMING cycle: React wins, and Score takes the pre-increment ms_cnt.
  - Start and React edges together in IDLE, DONE or FALSE: Start is accepted.

## Timing
- Reset values: state IDLE, Score 0, Load 0, Display 0, Stimulus 0, TooSoon 0, ms_cnt 0, prescaler 0, LFSR 16'hACE1.
- A clock edge with CLRN low forces all of the reset values, including mid-round. No Load is issued for an aborted round.
- Input edge → outputs:
  - React is sampled high at edge k, with Prev = 0.
  - Score, Load, Display and Stimulus change at edge k, i.e. a single-cycle latency.
  - Load drops at edge k+1.
- Stimulus rises at the edge at which the final WAIT tick is seen. The first TIMING tick then comes TICK_DIV cycles later.
- Wait length: exactly wait_ms·TICK_DIV cycles, measured from the Start-accept edge to the Stimulus rise.

## Configuration
- REACTION_FALSE_START_EN defined:
  - A React edge in WAIT goes to FALSE.
  - Score = 8191, Load = 1, Display = 1, TooSoon = 1.
  - Stimulus stays 0.
  - FALSE behaves like DONE.
- Undefined:
  - React edges in WAIT are ignored and the FALSE state is not built.
  - TooSoon is tied to 0.

## Test plan
All scenarios use TICK_DIV=4 and MIN_WAIT_MS=2.
- Reset: hold CLRN low for 3 cycles → all outputs 0. Start a round and raise React with Stimulus still low → no Stimulus and no Load until the Start edge.
- Normal round:
  - Start edge → Stimulus rises (2 + lfsr[10:0])·4 cycles later.
  - React edge after 10 ticks → Score = 10, single-cycle Load, Display = 1, Stimulus = 0.
- Timeout: no React after Stimulus → after 8191·4 cycles Score = 8191, Load pulses once.
- Held React: React held high from the start of WAIT through TIMING → no edge, so the round times out to 8191. (Assumes the macro is off, or React was already high before the Start edge.)
- False start:
  - Macro on, React edge in WAIT → Score = 8191, TooSoon = 1, Load pulse.
  - Macro off → React ignored and the round continues normally.
- Mid-round abort and restart:
  - CLRN low during TIMING → Stimulus = 0 next edge, no Load.
  - Start edge in DONE → Display = 0, the new round begins, and Score holds its previous value.
